// File: rtl/phase_sequencer.sv
// Five-phase multi-cycle control sequencer (IF/ID/EX/MEM/WB) driving datapath strobes.
// Optional performance counters are built when PHASE_SEQ_PERF_CNT_EN is defined.
module phase_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  OP,
  input  logic        Zeroflag,
  input  logic        Negflag,
  input  logic        mem_ready,
  output logic [2:0]  state,
  output logic [2:0]  next_state,
  output logic        ir_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic        rs1_we,
  output logic        sp_we,
  output logic        mem_req,
  output logic        mem_we,
  output logic        illegal,
  output logic [1:0]  pc_src,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
);

  typedef enum logic [2:0] {
    PH_IF  = 3'b000,
    PH_ID  = 3'b001,
    PH_EX  = 3'b010,
    PH_MEM = 3'b011,
    PH_WB  = 3'b100
  } phase_e;

  localparam logic [5:0] OP_LW    = 6'd5;
  localparam logic [5:0] OP_LWPOI = 6'd6;
  localparam logic [5:0] OP_SW    = 6'd7;
  localparam logic [5:0] OP_BGT   = 6'd8;
  localparam logic [5:0] OP_BLT   = 6'd9;
  localparam logic [5:0] OP_BEQ   = 6'd10;
  localparam logic [5:0] OP_BNE   = 6'd11;
  localparam logic [5:0] OP_JMP   = 6'd12;
  localparam logic [5:0] OP_CALL  = 6'd13;
  localparam logic [5:0] OP_RET   = 6'd14;
  localparam logic [5:0] OP_PUSH  = 6'd15;
  localparam logic [5:0] OP_POP   = 6'd16;

  localparam logic [1:0] PC_SEQ   = 2'b00;
  localparam logic [1:0] PC_BR    = 2'b01;
  localparam logic [1:0] PC_JMP   = 2'b10;
  localparam logic [1:0] PC_STACK = 2'b11;

  function automatic logic is_alu(input logic [5:0] op);
    return (op <= 6'd4);
  endfunction

  function automatic logic is_ldst(input logic [5:0] op);
    return (op >= OP_LW) && (op <= OP_SW);
  endfunction

  function automatic logic is_branch(input logic [5:0] op);
    return (op >= OP_BGT) && (op <= OP_BNE);
  endfunction

  function automatic logic is_stack(input logic [5:0] op);
    return (op >= OP_CALL) && (op <= OP_POP);
  endfunction

  function automatic logic wb_reaching(input logic [5:0] op);
    return is_alu(op) || (op == OP_LW) || (op == OP_LWPOI) || (op == OP_POP);
  endfunction

  function automatic logic branch_taken(input logic [5:0] op, input logic z, input logic n);
    logic taken;
    case (op)
      OP_BGT:  taken = ~z & ~n;
      OP_BLT:  taken = n;
      OP_BEQ:  taken = z;
      OP_BNE:  taken = ~z;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  phase_e     state_r;
  phase_e     next_state_s;
  logic       ir_we_s;
  logic       pc_we_s;
  logic       reg_we_s;
  logic       rs1_we_s;
  logic       sp_we_s;
  logic       mem_req_s;
  logic       mem_we_s;
  logic       illegal_s;
  logic [1:0] pc_src_s;

  // Phase register; reset wins over any pending transition, including memory waits
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= PH_IF;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-phase and strobe decode from phase, opcode, flags and memory handshake
  always_comb begin
    next_state_s = PH_IF;
    ir_we_s      = 1'b0;
    pc_we_s      = 1'b0;
    reg_we_s     = 1'b0;
    rs1_we_s     = 1'b0;
    sp_we_s      = 1'b0;
    mem_req_s    = 1'b0;
    mem_we_s     = 1'b0;
    illegal_s    = 1'b0;
    pc_src_s     = PC_SEQ;
    if (reset) begin
      next_state_s = PH_IF;
    end else begin
      case (state_r)
        PH_IF: begin
          mem_req_s = 1'b1;
          if (mem_ready) begin
            ir_we_s      = 1'b1;
            pc_we_s      = 1'b1;
            pc_src_s     = PC_SEQ;
            next_state_s = PH_ID;
          end else begin
            next_state_s = PH_IF;
          end
        end
        PH_ID: begin
          if (is_alu(OP) || is_ldst(OP) || is_branch(OP)) begin
            next_state_s = PH_EX;
          end else if (OP == OP_JMP) begin
            pc_we_s      = 1'b1;
            pc_src_s     = PC_JMP;
            next_state_s = PH_IF;
          end else if (is_stack(OP)) begin
            next_state_s = PH_MEM;
          end else begin
            illegal_s    = 1'b1;
            next_state_s = PH_IF;
          end
        end
        PH_EX: begin
          if (is_alu(OP)) begin
            next_state_s = PH_WB;
          end else if (is_ldst(OP)) begin
            next_state_s = PH_MEM;
          end else if (is_branch(OP)) begin
            // Not-taken branches leave the PC alone; fetch already advanced it
            if (branch_taken(OP, Zeroflag, Negflag)) begin
              pc_we_s  = 1'b1;
              pc_src_s = PC_BR;
            end else begin
              pc_we_s  = 1'b0;
              pc_src_s = PC_SEQ;
            end
            next_state_s = PH_IF;
          end else begin
            next_state_s = PH_IF;
          end
        end
        PH_MEM: begin
          if (is_ldst(OP) || is_stack(OP)) begin
            mem_req_s = 1'b1;
            if (mem_ready) begin
              case (OP)
                OP_LW, OP_LWPOI: begin
                  next_state_s = PH_WB;
                end
                OP_SW: begin
                  mem_we_s     = 1'b1;
                  next_state_s = PH_IF;
                end
                OP_CALL: begin
                  mem_we_s     = 1'b1;
                  sp_we_s      = 1'b1;
                  pc_we_s      = 1'b1;
                  pc_src_s     = PC_JMP;
                  next_state_s = PH_IF;
                end
                OP_RET: begin
                  sp_we_s      = 1'b1;
                  pc_we_s      = 1'b1;
                  pc_src_s     = PC_STACK;
                  next_state_s = PH_IF;
                end
                OP_PUSH: begin
                  mem_we_s     = 1'b1;
                  sp_we_s      = 1'b1;
                  next_state_s = PH_IF;
                end
                OP_POP: begin
                  sp_we_s      = 1'b1;
                  next_state_s = PH_WB;
                end
                default: begin
                  next_state_s = PH_IF;
                end
              endcase
            end else begin
              next_state_s = PH_MEM;
            end
          end else begin
            next_state_s = PH_IF;
          end
        end
        PH_WB: begin
          if (wb_reaching(OP)) begin
            reg_we_s = 1'b1;
            rs1_we_s = (OP == OP_LWPOI);
          end else begin
            reg_we_s = 1'b0;
            rs1_we_s = 1'b0;
          end
          next_state_s = PH_IF;
        end
        default: begin
          next_state_s = PH_IF;
        end
      endcase
    end
  end

  assign state      = state_r;
  assign next_state = next_state_s;
  assign ir_we      = ir_we_s;
  assign pc_we      = pc_we_s;
  assign reg_we     = reg_we_s;
  assign rs1_we     = rs1_we_s;
  assign sp_we      = sp_we_s;
  assign mem_req    = mem_req_s;
  assign mem_we     = mem_we_s;
  assign illegal    = illegal_s;
  assign pc_src     = pc_src_s;

`ifdef PHASE_SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt_r;
  logic [31:0] instr_cnt_r;

  // Performance counters; an instruction retires on every re-entry into IF
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_r <= 32'd0;
      instr_cnt_r <= 32'd0;
    end else begin
      cycle_cnt_r <= cycle_cnt_r + 32'd1;
      if ((state_r != PH_IF) && (next_state_s == PH_IF)) begin
        instr_cnt_r <= instr_cnt_r + 32'd1;
      end else begin
        instr_cnt_r <= instr_cnt_r;
      end
    end
  end

  assign cycle_cnt = cycle_cnt_r;
  assign instr_cnt = instr_cnt_r;
`else
  assign cycle_cnt = 32'd0;
  assign instr_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: directed instruction table, a reset-in-wait
// sequence, and randomized instructions against a per-instruction phase-path model.
module tb_phase_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  OP;
  logic        Zeroflag;
  logic        Negflag;
  logic        mem_ready;
  logic [2:0]  state;
  logic [2:0]  next_state;
  logic        ir_we, pc_we, reg_we, rs1_we, sp_we, mem_req, mem_we, illegal;
  logic [1:0]  pc_src;
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;

  localparam logic [2:0] S_IF  = 3'b000;
  localparam logic [2:0] S_ID  = 3'b001;
  localparam logic [2:0] S_EX  = 3'b010;
  localparam logic [2:0] S_MEM = 3'b011;
  localparam logic [2:0] S_WB  = 3'b100;

  int checks   = 0;
  int failures = 0;
  int obs_cycles;
  int obs_reg;
  logic [31:0] cyc_m = 32'd0;
  logic [31:0] ins_m = 32'd0;

  phase_sequencer dut (
    .clk(clk), .reset(reset), .OP(OP), .Zeroflag(Zeroflag), .Negflag(Negflag),
    .mem_ready(mem_ready), .state(state), .next_state(next_state),
    .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .rs1_we(rs1_we), .sp_we(sp_we),
    .mem_req(mem_req), .mem_we(mem_we), .illegal(illegal), .pc_src(pc_src),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // strobe vector: {ir_we,pc_we,reg_we,rs1_we,sp_we,mem_req,mem_we,illegal,pc_src}
  function automatic logic [9:0] sb(input bit ir, input bit pcw, input bit rw, input bit r1,
                                    input bit sp, input bit mrq, input bit mwe, input bit ill,
                                    input logic [1:0] src);
    return {ir, pcw, rw, r1, sp, mrq, mwe, ill, src};
  endfunction

  function automatic bit rb();
    return $urandom_range(0, 1) != 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs after falling edge, compare, then advance the counter model
  task automatic step(input bit rst, input logic [5:0] op, input bit z, input bit n, input bit mr,
                      input logic [2:0] est, input logic [2:0] enst, input logic [9:0] esb,
                      input bit full, input string name);
    logic [9:0] act;
    logic [31:0] ecyc;
    logic [31:0] eins;
    @(negedge clk);
    reset = rst; OP = op; Zeroflag = z; Negflag = n; mem_ready = mr;
    #1;
    act = {ir_we, pc_we, reg_we, rs1_we, sp_we, mem_req, mem_we, illegal, pc_src};
    if (full) check({name, " state"}, {29'd0, state}, {29'd0, est});
    check({name, " next_state"}, {29'd0, next_state}, {29'd0, enst});
    check({name, " strobes"}, {22'd0, act}, {22'd0, esb});
`ifdef PHASE_SEQ_PERF_CNT_EN
    ecyc = cyc_m;
    eins = ins_m;
`else
    ecyc = 32'd0;
    eins = 32'd0;
`endif
    if (full) begin
      check({name, " cycle_cnt"}, cycle_cnt, ecyc);
      check({name, " instr_cnt"}, instr_cnt, eins);
    end
    obs_cycles++;
    if (reg_we === 1'b1) obs_reg++;
    if (rst) begin
      cyc_m = 32'd0;
      ins_m = 32'd0;
    end else begin
      cyc_m = cyc_m + 32'd1;
      if ((est != S_IF) && (enst == S_IF)) ins_m = ins_m + 32'd1;
    end
  endtask

  // Walk one instruction through its phase path as dictated by its opcode class
  task automatic run_instr(input logic [5:0] op, input bit z, input bit n, input int ifw, input int memw);
    bit tk;
    obs_cycles = 0;
    obs_reg    = 0;
    for (int i = 0; i < ifw; i++)
      step(1'b0, op, rb(), rb(), 1'b0, S_IF, S_IF, sb(0,0,0,0,0,1,0,0,2'b00), 1'b1, "if_wait");
    step(1'b0, op, rb(), rb(), 1'b1, S_IF, S_ID, sb(1,1,0,0,0,1,0,0,2'b00), 1'b1, "if_fetch");
    if (op == 6'd12) begin
      step(1'b0, op, rb(), rb(), rb(), S_ID, S_IF, sb(0,1,0,0,0,0,0,0,2'b10), 1'b1, "id_jmp");
      return;
    end
    if (op > 6'd16) begin
      step(1'b0, op, rb(), rb(), rb(), S_ID, S_IF, sb(0,0,0,0,0,0,0,1,2'b00), 1'b1, "id_illegal");
      return;
    end
    if (op >= 6'd13) begin
      step(1'b0, op, rb(), rb(), rb(), S_ID, S_MEM, sb(0,0,0,0,0,0,0,0,2'b00), 1'b1, "id_stack");
    end else begin
      step(1'b0, op, rb(), rb(), rb(), S_ID, S_EX, sb(0,0,0,0,0,0,0,0,2'b00), 1'b1, "id_ex");
      if (op <= 6'd4) begin
        step(1'b0, op, rb(), rb(), rb(), S_EX, S_WB, sb(0,0,0,0,0,0,0,0,2'b00), 1'b1, "ex_alu");
        step(1'b0, op, rb(), rb(), rb(), S_WB, S_IF, sb(0,0,1,0,0,0,0,0,2'b00), 1'b1, "wb_alu");
        return;
      end
      if (op >= 6'd8) begin
        case (op)
          6'd8:    tk = !z && !n;
          6'd9:    tk = n;
          6'd10:   tk = z;
          default: tk = !z;
        endcase
        step(1'b0, op, z, n, rb(), S_EX, S_IF, sb(0,tk,0,0,0,0,0,0,tk ? 2'b01 : 2'b00), 1'b1, "ex_branch");
        return;
      end
      step(1'b0, op, rb(), rb(), rb(), S_EX, S_MEM, sb(0,0,0,0,0,0,0,0,2'b00), 1'b1, "ex_ldst");
    end
    for (int i = 0; i < memw; i++)
      step(1'b0, op, rb(), rb(), 1'b0, S_MEM, S_MEM, sb(0,0,0,0,0,1,0,0,2'b00), 1'b1, "mem_wait");
    case (op)
      6'd5, 6'd6: step(1'b0, op, rb(), rb(), 1'b1, S_MEM, S_WB, sb(0,0,0,0,0,1,0,0,2'b00), 1'b1, "mem_load");
      6'd7:  step(1'b0, op, rb(), rb(), 1'b1, S_MEM, S_IF, sb(0,0,0,0,0,1,1,0,2'b00), 1'b1, "mem_sw");
      6'd13: step(1'b0, op, rb(), rb(), 1'b1, S_MEM, S_IF, sb(0,1,0,0,1,1,1,0,2'b10), 1'b1, "mem_call");
      6'd14: step(1'b0, op, rb(), rb(), 1'b1, S_MEM, S_IF, sb(0,1,0,0,1,1,0,0,2'b11), 1'b1, "mem_ret");
      6'd15: step(1'b0, op, rb(), rb(), 1'b1, S_MEM, S_IF, sb(0,0,0,0,1,1,1,0,2'b00), 1'b1, "mem_push");
      default: step(1'b0, op, rb(), rb(), 1'b1, S_MEM, S_WB, sb(0,0,0,0,1,1,0,0,2'b00), 1'b1, "mem_pop");
    endcase
    if (op == 6'd5 || op == 6'd6 || op == 6'd16)
      step(1'b0, op, rb(), rb(), rb(), S_WB, S_IF, sb(0,0,1,op == 6'd6,0,0,0,0,2'b00), 1'b1, "wb_mem");
  endtask

  typedef struct {
    logic [5:0] op;
    bit         z;
    bit         n;
    int         ifw;
    int         memw;
    int         exp_len;
    int         exp_reg;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{6'd1,  1'b0, 1'b0, 0, 0, 4, 1};  // ADD
    vecs[1]  = '{6'd6,  1'b0, 1'b0, 0, 2, 7, 1};  // LW.POI, two wait cycles
    vecs[2]  = '{6'd10, 1'b1, 1'b0, 0, 0, 3, 0};  // BEQ taken
    vecs[3]  = '{6'd10, 1'b0, 1'b0, 0, 0, 3, 0};  // BEQ not taken
    vecs[4]  = '{6'd13, 1'b0, 1'b0, 0, 0, 3, 0};  // CALL
    vecs[5]  = '{6'd14, 1'b0, 1'b0, 0, 0, 3, 0};  // RET
    vecs[6]  = '{6'd17, 1'b0, 1'b0, 0, 0, 2, 0};  // first illegal opcode
    vecs[7]  = '{6'd12, 1'b0, 1'b0, 1, 0, 3, 0};  // JMP after a fetch wait
    vecs[8]  = '{6'd8,  1'b0, 1'b0, 0, 0, 3, 0};  // BGT taken
    vecs[9]  = '{6'd9,  1'b0, 1'b1, 0, 0, 3, 0};  // BLT taken
    vecs[10] = '{6'd11, 1'b1, 1'b0, 0, 0, 3, 0};  // BNE not taken
    vecs[11] = '{6'd16, 1'b0, 1'b0, 0, 1, 5, 1};  // POP
    vecs[12] = '{6'd7,  1'b0, 1'b0, 2, 0, 6, 0};  // SW
    vecs[13] = '{6'd15, 1'b0, 1'b0, 0, 0, 3, 0};  // PUSH
    vecs[14] = '{6'd3,  1'b0, 1'b0, 1, 0, 5, 1};  // ANDI

    reset = 1'b1; OP = 6'd0; Zeroflag = 1'b0; Negflag = 1'b0; mem_ready = 1'b0;
    step(1'b1, 6'd1, 1'b1, 1'b1, 1'b1, S_IF, S_IF, 10'd0, 1'b0, "reset0");
    step(1'b1, 6'd13, 1'b1, 1'b0, 1'b1, S_IF, S_IF, 10'd0, 1'b1, "reset1");

    for (int i = 0; i < 15; i++) begin
      run_instr(vecs[i].op, vecs[i].z, vecs[i].n, vecs[i].ifw, vecs[i].memw);
      check($sformatf("vec%0d cycles", i), 32'(obs_cycles), 32'(vecs[i].exp_len));
      check($sformatf("vec%0d reg_we", i), 32'(obs_reg), 32'(vecs[i].exp_reg));
    end

    // reset arriving while SW waits on memory, with mem_ready rising in the same cycle
    step(1'b0, 6'd7, 1'b0, 1'b0, 1'b1, S_IF, S_ID, sb(1,1,0,0,0,1,0,0,2'b00), 1'b1, "rst_sw_fetch");
    step(1'b0, 6'd7, 1'b0, 1'b0, 1'b0, S_ID, S_EX, 10'd0, 1'b1, "rst_sw_id");
    step(1'b0, 6'd7, 1'b0, 1'b0, 1'b0, S_EX, S_MEM, 10'd0, 1'b1, "rst_sw_ex");
    step(1'b0, 6'd7, 1'b0, 1'b0, 1'b0, S_MEM, S_MEM, sb(0,0,0,0,0,1,0,0,2'b00), 1'b1, "rst_sw_wait");
    step(1'b1, 6'd7, 1'b0, 1'b0, 1'b1, S_MEM, S_IF, 10'd0, 1'b1, "rst_sw_reset");
    step(1'b0, 6'd7, 1'b0, 1'b0, 1'b0, S_IF, S_IF, sb(0,0,0,0,0,1,0,0,2'b00), 1'b1, "rst_sw_after");

    for (int i = 0; i < 150; i++)
      run_instr(6'($urandom_range(0, 20)), rb(), rb(), $urandom_range(0, 2), $urandom_range(0, 3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
